// File: rtl/bytecode_prefetch_queue.sv
// JVM bytecode prefetch queue: byte-wide fetch FSM feeding a circular buffer that
// presents a WINDOW-byte decode window. Optional fetch halt at RAM_SIZE: BYTECODE_FETCH_BOUNDS_EN.

module bpq_window_lane #(
  parameter int QUEUE_DEPTH = 8,
  parameter int PW          = 3
) (
  input  logic [QUEUE_DEPTH-1:0][7:0] qmem_i,
  input  logic [PW-1:0]               idx_i,
  input  logic                        push_i,
  input  logic [PW-1:0]               wr_ptr_i,
  input  logic [7:0]                  data_i,
  output logic [7:0]                  byte_o
);
  // Bypass the byte being written this cycle so the window is current one cycle after the response.
  assign byte_o = (push_i && idx_i == wr_ptr_i) ? data_i : qmem_i[idx_i];
endmodule

module bytecode_prefetch_queue #(
  parameter  int RAM_SIZE      = 256,
  parameter  int ADDRESS_WIDTH = 8,
  parameter  int QUEUE_DEPTH   = 8,
  parameter  int WINDOW        = 4,
  localparam int CW            = $clog2(WINDOW + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_reset_value_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  input  logic                     consume_i,
  input  logic [CW-1:0]            consume_count_i,
  output logic [8*WINDOW-1:0]      window_o,
  output logic [CW-1:0]            avail_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic                     consume_err_o,
  output logic                     out_of_range_o,
  output logic [ADDRESS_WIDTH-1:0] mem_address_o,
  output logic                     mem_start_o,
  input  logic [7:0]               mem_data_i,
  input  logic                     mem_ready_i
);
  localparam int PW   = $clog2(QUEUE_DEPTH);
  localparam int CNTW = $clog2(QUEUE_DEPTH + 1);

  if (QUEUE_DEPTH < WINDOW || QUEUE_DEPTH < 2 || RAM_SIZE < 1) begin : g_bad_cfg
    $error("bytecode_prefetch_queue: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e                          state_q, state_d;
  logic [QUEUE_DEPTH-1:0][7:0]     qmem_q;
  logic [PW-1:0]                   rd_q, rd_d, wr_q, wr_d;
  logic [CNTW-1:0]                 count_q, count_d, cur_avail;
  logic [ADDRESS_WIDTH-1:0]        pc_q, pc_d, fpc_q, fpc_d, maddr_q, maddr_d;
  logic [WINDOW-1:0][7:0]          win_q, win_d;
  logic [CW-1:0]                   avail_q, avail_d, pop;
  logic                            mstart_q, err_q, err_d, halt_q, halt_d;
  logic                            cons_ok, push, start, halted;

`ifdef BYTECODE_FETCH_BOUNDS_EN
  assign halted = halt_q;
  always_comb begin
    halt_d = halt_q;
    if (redirect_i)
      halt_d = int'(redirect_pc_i) >= RAM_SIZE;
    else if (state_q == REQ && fpc_q == ADDRESS_WIDTH'(RAM_SIZE - 1))
      halt_d = 1'b1;
  end
`else
  assign halted = 1'b0;
  assign halt_d = 1'b0;
`endif

  always_comb begin
    cur_avail = (count_q > CNTW'(WINDOW)) ? CNTW'(WINDOW) : count_q;
    cons_ok   = consume_i && consume_count_i != '0 && CNTW'(consume_count_i) <= cur_avail;
    pop       = cons_ok ? consume_count_i : '0;
    push      = state_q == WAIT && mem_ready_i && !redirect_i;
    // In IDLE nothing is outstanding, so count alone bounds the queue.
    start     = state_q == IDLE && !redirect_i && !halted && count_q < CNTW'(QUEUE_DEPTH);

    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     state_d = redirect_i ? DROP : WAIT;
      // A response arriving with the redirect is already consumed, so no DROP is needed.
      WAIT:    if (mem_ready_i) state_d = IDLE;
               else if (redirect_i) state_d = DROP;
      DROP:    if (mem_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    fpc_d   = fpc_q;
    maddr_d = maddr_q;
    if (redirect_i)          fpc_d = redirect_pc_i;
    else if (state_q == REQ) fpc_d = fpc_q + 1'b1;
    if (start)               maddr_d = fpc_q;

    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      err_d   = 1'b0;
    end else begin
      pc_d    = pc_q + ADDRESS_WIDTH'(pop);
      count_d = count_q - CNTW'(pop) + CNTW'(push);
      rd_d    = rd_q + PW'(pop);
      wr_d    = wr_q + PW'(push);
      err_d   = consume_i && !cons_ok;
    end
    avail_d = CW'((count_d > CNTW'(WINDOW)) ? CNTW'(WINDOW) : count_d);
  end

  for (genvar i = 0; i < WINDOW; i++) begin : g_lane
    bpq_window_lane #(.QUEUE_DEPTH(QUEUE_DEPTH), .PW(PW)) u_lane (
      .qmem_i   (qmem_q),
      .idx_i    (rd_d + PW'(i)),
      .push_i   (push),
      .wr_ptr_i (wr_q),
      .data_i   (mem_data_i),
      .byte_o   (win_d[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (push) qmem_q[wr_q] <= mem_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      pc_q     <= pc_reset_value_i;
      fpc_q    <= pc_reset_value_i;
      maddr_q  <= '0;
      mstart_q <= 1'b0;
      win_q    <= '0;
      avail_q  <= '0;
      err_q    <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      fpc_q    <= fpc_d;
      maddr_q  <= maddr_d;
      mstart_q <= start;
      win_q    <= win_d;
      avail_q  <= avail_d;
      err_q    <= err_d;
      halt_q   <= halt_d;
    end
  end

  assign window_o       = win_q;
  assign avail_o        = avail_q;
  assign pc_o           = pc_q;
  assign consume_err_o  = err_q;
  assign out_of_range_o = halt_q;
  assign mem_address_o  = maddr_q;
  assign mem_start_o    = mstart_q;
endmodule
